// File: rtl/pcm_downlink_sim.sv
// PCM downlink telemetry simulator: derives DKSTRT/DKBSNC/DKEND from the AGC
// clock, captures the DKDATA serial stream into words and buffers them in a
// small FIFO drained through a valid/ready handshake.
// Handshake: a word moves to the consumer on every rising clk edge where
// word_valid and word_ready are both high; word_data holds steady otherwise.
module pcm_downlink_sim #(
    parameter int PULSE_DIV   = 20,
    parameter int PULSE_WIDTH = 4,
    parameter int WORD_BITS   = 40,
    parameter int FRAME_SLOTS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 agc_clk_in,
    input  logic                 dkdata,
    output logic                 dkstrt,
    output logic                 dkbsnc,
    output logic                 dkend,
    output logic                 word_valid,
    output logic [WORD_BITS-1:0] word_data,
    input  logic                 word_ready,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic [15:0]          word_count
);

    localparam int PT_W = $clog2(PULSE_DIV);
    localparam int SL_W = $clog2(FRAME_SLOTS);
    localparam int BX_W = $clog2(WORD_BITS + 3);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [PT_W-1:0] PT_LAST = PT_W'(PULSE_DIV - 1);
    localparam logic [PT_W-1:0] PT_CAP  = PT_W'(PULSE_WIDTH - 1);
    localparam logic [PT_W-1:0] PT_WID  = PT_W'(PULSE_WIDTH);
    localparam logic [SL_W-1:0] SL_LAST = SL_W'(FRAME_SLOTS - 1);
    localparam logic [BX_W-1:0] BX_WB   = BX_W'(WORD_BITS);
    localparam logic [BX_W-1:0] BX_END  = BX_W'(WORD_BITS + 1);
    localparam logic [BX_W-1:0] BX_IDLE = BX_W'(WORD_BITS + 2);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic                 r_ac_s1, r_ac_s2, r_ac_prev;
    logic                 r_dk_s1, r_dk_s2;
    logic [PT_W-1:0]      r_ptmr;
    logic [SL_W-1:0]      r_slot;
    logic [BX_W-1:0]      r_bidx;
    logic                 r_dkstrt, r_dkbsnc, r_dkend;
    logic [WORD_BITS-1:0] r_shift;
    logic                 r_frame_ok;
    logic [WORD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_count;
    logic                 r_overflow;
    logic [15:0]          r_word_count;

    logic                 w_edge, w_pt_wrap, w_in_pulse, w_is_bit, w_cap;
    logic                 w_push, w_pop, w_full, w_push_ok, w_drop;
    logic [SL_W-1:0]      w_slot_next;

    assign w_edge      = r_ac_s2 & ~r_ac_prev;
    assign w_pt_wrap   = w_edge && (r_ptmr == PT_LAST);
    assign w_slot_next = (r_slot == SL_LAST) ? '0 : r_slot + 1'b1;
    assign w_in_pulse  = (r_ptmr < PT_WID);
    assign w_is_bit    = (r_bidx != '0) && (r_bidx <= BX_WB);
    // Capture point is the strobe trailing edge; disabled frames never capture.
    assign w_cap       = w_edge && (r_ptmr == PT_CAP) && enable;
    assign w_push      = w_cap && (r_bidx == BX_END) && r_frame_ok;
    assign w_pop       = word_valid && word_ready;
    assign w_full      = (r_count == CNT_FULL);
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;

    // Two-flop synchronizers for the asynchronous AGC signals plus edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac_s1   <= 1'b0;
            r_ac_s2   <= 1'b0;
            r_ac_prev <= 1'b0;
            r_dk_s1   <= 1'b0;
            r_dk_s2   <= 1'b0;
        end else begin
            r_ac_s1   <= agc_clk_in;
            r_ac_s2   <= r_ac_s1;
            r_ac_prev <= r_ac_s2;
            r_dk_s1   <= dkdata;
            r_dk_s2   <= r_dk_s1;
        end
    end

    // Frame geometry counters: pulse timer, bit slot and word bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptmr <= '0;
            r_slot <= SL_LAST;
            r_bidx <= BX_IDLE;
        end else if (w_edge) begin
            r_ptmr <= w_pt_wrap ? '0 : r_ptmr + 1'b1;
            if (w_pt_wrap) begin
                r_slot <= w_slot_next;
                if (w_slot_next == '0) begin
                    r_bidx <= '0;
                end else if (r_bidx != BX_IDLE) begin
                    r_bidx <= r_bidx + 1'b1;
                end
            end
        end
    end

    // Registered strobe decode from counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dkstrt <= 1'b0;
            r_dkbsnc <= 1'b0;
            r_dkend  <= 1'b0;
        end else begin
            r_dkstrt <= enable && w_in_pulse && (r_bidx == '0);
            r_dkbsnc <= enable && w_in_pulse && w_is_bit;
            r_dkend  <= enable && w_in_pulse && (r_bidx == BX_END);
        end
    end

    // Serial capture; a frame only completes if enable stayed high since its start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_frame_ok <= 1'b0;
        end else if (!enable) begin
            r_frame_ok <= 1'b0;
        end else if (w_cap) begin
            if (r_bidx == '0) begin
                r_shift    <= '0;
                r_frame_ok <= 1'b1;
            end else if (w_is_bit) begin
                r_shift <= (r_shift << 1) | WORD_BITS'(r_dk_s2);
            end else if (r_bidx == BX_END) begin
                r_frame_ok <= 1'b0;
            end
        end
    end

    // Word FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};
        end
    end

    // Sticky overflow (a drop beats a clear) and the push attempt counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_drop)            r_overflow <= 1'b1;
            else if (overflow_clr) r_overflow <= 1'b0;
            if (w_push) r_word_count <= r_word_count + 16'd1;
        end
    end

    assign dkstrt     = r_dkstrt;
    assign dkbsnc     = r_dkbsnc;
    assign dkend      = r_dkend;
    assign word_valid = (r_count != '0);
    assign word_data  = r_mem[r_rptr];
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule
